// File: rtl/pc_control.sv
// Next-PC selection and PC register for the WISC fetch stage.
// Chooses sequential, PC-relative branch, register branch or hold, registered once per cycle.
module pc_control (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  opcode,
  input  logic [2:0]  C,
  input  logic [8:0]  I,
  input  logic [2:0]  F,
  input  logic [15:0] PC_in,
  input  logic [15:0] data_in,
  output logic [15:0] PC_out,
  output logic        taken
);

  typedef enum logic [1:0] {
    OpSeq = 2'b00,
    OpB   = 2'b01,
    OpBr  = 2'b10,
    OpHlt = 2'b11
  } pc_op_e;

  logic        flag_z, flag_v, flag_n;
  logic        cond;
  logic [15:0] seq;
  logic [15:0] b_off;
  logic [15:0] nxt;
  logic        taken_nxt;

  assign flag_z = F[2];
  assign flag_v = F[1];
  assign flag_n = F[0];

  assign seq   = PC_in + 16'd2;
  // Word offset: sign-extend the 9-bit field, then scale to a byte offset.
  assign b_off = {{6{I[8]}}, I, 1'b0};

  always_comb begin
    cond = 1'b0;
    case (C)
      3'b000:  cond = ~flag_z;
      3'b001:  cond = flag_z;
      3'b010:  cond = ~flag_z & ~flag_n;
      3'b011:  cond = flag_n;
      3'b100:  cond = flag_z | ~flag_n;
      3'b101:  cond = flag_n | flag_z;
      3'b110:  cond = flag_v;
      default: cond = 1'b1;
    endcase
  end

  always_comb begin
    nxt       = seq;
    taken_nxt = 1'b0;
    case (pc_op_e'(opcode))
      OpSeq: nxt = seq;
      OpB: begin
        nxt       = cond ? (seq + b_off) : seq;
        taken_nxt = cond;
      end
      OpBr: begin
        nxt       = cond ? data_in : seq;
        taken_nxt = cond;
      end
      OpHlt: nxt = PC_in;
      default: begin
        nxt       = seq;
        taken_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      PC_out <= 16'h0000;
      taken  <= 1'b0;
    end else begin
      PC_out <= nxt;
      taken  <= taken_nxt;
    end
  end

endmodule

// File: tb/tb_pc_control.sv
// Self-checking bench for pc_control: directed plan steps, exhaustive B/BR sweeps, random run
// against an arithmetic reference model.
module tb_pc_control;

  logic        clk;
  logic        rst;
  logic [1:0]  opcode;
  logic [2:0]  C;
  logic [8:0]  I;
  logic [2:0]  F;
  logic [15:0] PC_in;
  logic [15:0] data_in;
  logic [15:0] PC_out;
  logic        taken;

  int n_checks = 0;
  int n_fail   = 0;

  pc_control dut (
    .clk     (clk),
    .rst     (rst),
    .opcode  (opcode),
    .C       (C),
    .I       (I),
    .F       (F),
    .PC_in   (PC_in),
    .data_in (data_in),
    .PC_out  (PC_out),
    .taken   (taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Condition table from the branch-code definitions; flags named for readability.
  function automatic bit model_cond(input logic [2:0] c, input logic [2:0] f);
    bit z, v, n;
    z = f[2];
    v = f[1];
    n = f[0];
    case (c)
      3'd0:    return !z;
      3'd1:    return z;
      3'd2:    return !z && !n;
      3'd3:    return n;
      3'd4:    return z || (!z && !n);
      3'd5:    return n || z;
      3'd6:    return v;
      default: return 1'b1;
    endcase
  endfunction

  // Integer arithmetic on the byte address, reduced modulo 65536.
  function automatic logic [15:0] model_pc(input logic [1:0] op, input logic [2:0] c,
                                           input logic [8:0] i, input logic [2:0] f,
                                           input logic [15:0] pc, input logic [15:0] d);
    int words;
    int addr;
    words = (int'(i) >= 256) ? int'(i) - 512 : int'(i);
    if (op == 2'd3) return pc;
    if (op == 2'd1 && model_cond(c, f)) begin
      addr = int'(pc) + 2 + 2 * words;
      addr = ((addr % 65536) + 65536) % 65536;
      return 16'(addr);
    end
    if (op == 2'd2 && model_cond(c, f)) return d;
    addr = (int'(pc) + 2) % 65536;
    return 16'(addr);
  endfunction

  function automatic bit model_taken(input logic [1:0] op, input logic [2:0] c,
                                     input logic [2:0] f);
    return (op == 2'd1 || op == 2'd2) && model_cond(c, f);
  endfunction

  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic [2:0] c, input logic [8:0] i,
                       input logic [2:0] f, input logic [15:0] pc, input logic [15:0] d);
    opcode  = op;
    C       = c;
    I       = i;
    F       = f;
    PC_in   = pc;
    data_in = d;
  endtask

  // Drive, clock once, sample 1 time unit after the edge and compare with the model.
  task automatic step_check(input string tag, input logic [1:0] op, input logic [2:0] c,
                            input logic [8:0] i, input logic [2:0] f, input logic [15:0] pc,
                            input logic [15:0] d);
    drive(op, c, i, f, pc, d);
    @(posedge clk);
    #1;
    check16({tag, "_pc"}, PC_out, model_pc(op, c, i, f, pc, d));
    check1({tag, "_taken"}, taken, model_taken(op, c, f));
  endtask

  initial begin
    rst = 1'b0;
    drive(2'b10, 3'b111, 9'h0AB, 3'b111, 16'hBEEF, 16'h5A5A);

    // 1. Reset takes effect before any clock edge
    #1 rst = 1'b1;
    #1;
    check16("rst_async_pc", PC_out, 16'h0000);
    check1("rst_async_taken", taken, 1'b0);
    drive(2'b00, 3'b000, 9'h000, 3'b000, 16'h0000, 16'h0000);
    @(posedge clk);
    #1;
    check16("rst_edge_hold_pc", PC_out, 16'h0000);
    check1("rst_edge_hold_taken", taken, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check16("first_seq", PC_out, 16'h0002);
    check1("first_seq_taken", taken, 1'b0);

    // 2/3. B and BR sweeps over all condition codes and flag patterns
    for (int op = 1; op <= 2; op++) begin
      for (int c = 0; c < 8; c++) begin
        for (int f = 0; f < 8; f++) begin
          step_check(op == 1 ? "b_sweep" : "br_sweep", 2'(op), 3'(c), 9'h003, 3'(f),
                     16'h0001, 16'h111F);
          if (c == 7) check16("always_fixed", PC_out, (op == 1) ? 16'h0009 : 16'h111F);
          if (c == 6) check16("ov_fixed", PC_out,
                              f[1] ? ((op == 1) ? 16'h0009 : 16'h111F) : 16'h0003);
        end
      end
    end
    step_check("br_ne_z", 2'b10, 3'b000, 9'h003, 3'b100, 16'h0001, 16'h111F);
    check16("br_ne_z_fixed", PC_out, 16'h0003);
    step_check("br_eq_z", 2'b10, 3'b001, 9'h003, 3'b100, 16'h0001, 16'h111F);
    check16("br_eq_z_fixed", PC_out, 16'h111F);

    // 4. Negative offsets
    step_check("b_self", 2'b01, 3'b111, 9'h1FF, 3'b000, 16'h0010, 16'h0000);
    check16("b_self_fixed", PC_out, 16'h0010);
    step_check("b_neg256", 2'b01, 3'b111, 9'h100, 3'b000, 16'h0100, 16'h0000);
    check16("b_neg256_fixed", PC_out, 16'hFF02);

    // 5. Sequential wrap and halt
    step_check("seq_wrap", 2'b00, 3'b111, 9'h1AA, 3'b111, 16'hFFFE, 16'h7777);
    check16("seq_wrap_fixed", PC_out, 16'h0000);
    for (int c = 0; c < 8; c += 3) begin
      step_check("hlt", 2'b11, 3'(c), 9'h055, 3'(7 - c), 16'h1234, 16'h4321);
      check16("hlt_fixed", PC_out, 16'h1234);
      check1("hlt_taken_fixed", taken, 1'b0);
    end

    // 6. Asynchronous reset between edges
    step_check("pre_rst_br", 2'b10, 3'b111, 9'h000, 3'b000, 16'h0040, 16'h111F);
    check16("pre_rst_fixed", PC_out, 16'h111F);
    #2 rst = 1'b1;
    #1;
    check16("mid_rst_pc", PC_out, 16'h0000);
    check1("mid_rst_taken", taken, 1'b0);
    #1 rst = 1'b0;
    step_check("post_rst", 2'b01, 3'b001, 9'h010, 3'b100, 16'h0200, 16'h0000);
    check16("post_rst_fixed", PC_out, 16'h0222);

    // Random run against the model
    for (int k = 0; k < 300; k++) begin
      step_check("rand", 2'($urandom), 3'($urandom), 9'($urandom), 3'($urandom),
                 16'($urandom), 16'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    n_fail++;
    $display("FAIL timeout: observed no completion expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "timeout");
  end

endmodule
